// File: rtl/md_pkg.sv
// Shared constants, FSM encoding and bus packing order for the motion-update dispatcher.
package md_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int CELL_ID_WIDTH = 4;
  localparam int OFFSET_WIDTH  = DATA_WIDTH - CELL_ID_WIDTH;
  localparam int ADDR_WIDTH    = 8;
  localparam int PARTICLE_NUM  = 220;
  localparam int CELL_NUM_X    = 3;
  localparam int CELL_NUM_Y    = 3;
  localparam int CELL_NUM_Z    = 3;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RD_COUNT   = 3'd1,
    ST_WAIT_COUNT = 3'd2,
    ST_RD_PART    = 3'd3,
    ST_DRAIN      = 3'd4,
    ST_SETTLE     = 3'd5,
    ST_DONE       = 3'd6
  } md_state_t;

  typedef logic [CELL_ID_WIDTH-1:0] cell_id_t;
  typedef logic [DATA_WIDTH-1:0]    coord_t;

  // Cell IDs travel as {x,y,z}; coordinates travel as {z,y,x}.
  function automatic logic [3*CELL_ID_WIDTH-1:0] pack_cell(input cell_id_t x, input cell_id_t y,
                                                          input cell_id_t z);
    return {x, y, z};
  endfunction

  function automatic logic [3*DATA_WIDTH-1:0] pack_data(input coord_t x, input coord_t y,
                                                       input coord_t z);
    return {z, y, x};
  endfunction

endpackage

// File: rtl/motion_update_dispatch_pos_wrap.sv
// One axis of the integration step: position plus displacement, cell field wrapped periodically.
module pos_wrap #(
  parameter int DATA_WIDTH    = 32,
  parameter int CELL_ID_WIDTH = 4,
  parameter int OFFSET_WIDTH  = DATA_WIDTH - CELL_ID_WIDTH,
  parameter int CELL_NUM      = 3
) (
  input  logic [DATA_WIDTH-1:0]    pos,
  input  logic [DATA_WIDTH-1:0]    vel,
  output logic [DATA_WIDTH-1:0]    new_pos,
  output logic [CELL_ID_WIDTH-1:0] new_cell
);

  localparam logic [CELL_ID_WIDTH-1:0] CELL_MAX  = CELL_ID_WIDTH'(CELL_NUM);
  localparam logic [CELL_ID_WIDTH-1:0] CELL_OVER = CELL_ID_WIDTH'(CELL_NUM + 1);
  localparam logic [CELL_ID_WIDTH-1:0] CELL_ONE  = CELL_ID_WIDTH'(1);

  logic [DATA_WIDTH-1:0]    sum_s;
  logic [CELL_ID_WIDTH-1:0] field_s;

  // Displacement is bounded below one cell, so the field lands at most one step outside 1..N.
  always_comb begin
    sum_s   = pos + vel;
    field_s = sum_s[DATA_WIDTH-1 -: CELL_ID_WIDTH];
    if (field_s == {CELL_ID_WIDTH{1'b0}}) begin
      new_cell = CELL_MAX;
    end else if (field_s == CELL_OVER) begin
      new_cell = CELL_ONE;
    end else begin
      new_cell = field_s;
    end
    new_pos = {new_cell, sum_s[OFFSET_WIDTH-1:0]};
  end

endmodule

// File: rtl/motion_update_dispatch.sv
// Walks every cell, reads count/positions/velocities, and broadcasts integrated positions
// with their destination cell on the shared motion-update bus.
module motion_update_dispatch #(
  parameter int DATA_WIDTH    = 32,
  parameter int CELL_ID_WIDTH = 4,
  parameter int OFFSET_WIDTH  = DATA_WIDTH - CELL_ID_WIDTH,
  parameter int ADDR_WIDTH    = 8,
  parameter int PARTICLE_NUM  = 220,
  parameter int CELL_NUM_X    = 3,
  parameter int CELL_NUM_Y    = 3,
  parameter int CELL_NUM_Z    = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [3*CELL_ID_WIDTH-1:0] out_rd_cell,
  output logic [ADDR_WIDTH-1:0]      out_rd_address,
  output logic                       out_rd_en,
  input  logic [3*DATA_WIDTH-1:0]    in_pos,
  input  logic [3*DATA_WIDTH-1:0]    in_vel,
  output logic                       out_motion_update_enable,
  output logic [3*DATA_WIDTH-1:0]    out_data,
  output logic [3*CELL_ID_WIDTH-1:0] out_data_dst_cell,
  output logic                       out_data_valid,
  output logic                       out_busy,
  output logic                       out_done
);
  import md_pkg::*;

  localparam logic [CELL_ID_WIDTH-1:0] NX       = CELL_ID_WIDTH'(CELL_NUM_X);
  localparam logic [CELL_ID_WIDTH-1:0] NY       = CELL_ID_WIDTH'(CELL_NUM_Y);
  localparam logic [CELL_ID_WIDTH-1:0] NZ       = CELL_ID_WIDTH'(CELL_NUM_Z);
  localparam logic [CELL_ID_WIDTH-1:0] CELL_ONE = CELL_ID_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0]    PART_MAX = ADDR_WIDTH'(PARTICLE_NUM);
  localparam logic [ADDR_WIDTH-1:0]    ADDR_ONE = ADDR_WIDTH'(1);

  md_state_t                state_r;
  logic [CELL_ID_WIDTH-1:0] cell_x_r, cell_y_r, cell_z_r;
  logic [CELL_ID_WIDTH-1:0] nxt_x_s, nxt_y_s, nxt_z_s;
  logic                     last_cell_s;
  logic [ADDR_WIDTH-1:0]    count_r;
  logic [ADDR_WIDTH-1:0]    count_in_s;
  logic                     advance_s;
  logic [1:0]               wait_r;
  logic                     pend_r;

  logic [DATA_WIDTH-1:0]    new_x_s, new_y_s, new_z_s;
  logic [CELL_ID_WIDTH-1:0] dst_x_s, dst_y_s, dst_z_s;

  // Next cell in z-fastest order, wrapping back to (1,1,1) after the last one.
  always_comb begin
    nxt_x_s     = cell_x_r;
    nxt_y_s     = cell_y_r;
    nxt_z_s     = cell_z_r;
    last_cell_s = (cell_x_r == NX) && (cell_y_r == NY) && (cell_z_r == NZ);
    if (cell_z_r != NZ) begin
      nxt_z_s = cell_z_r + CELL_ONE;
    end else begin
      nxt_z_s = CELL_ONE;
      if (cell_y_r != NY) begin
        nxt_y_s = cell_y_r + CELL_ONE;
      end else begin
        nxt_y_s = CELL_ONE;
        if (cell_x_r != NX) begin
          nxt_x_s = cell_x_r + CELL_ONE;
        end else begin
          nxt_x_s = CELL_ONE;
        end
      end
    end
  end

  // Saturated particle count and the "this cell is finished" condition.
  always_comb begin
    if (in_pos[ADDR_WIDTH-1:0] > PART_MAX) begin
      count_in_s = PART_MAX;
    end else begin
      count_in_s = in_pos[ADDR_WIDTH-1:0];
    end
    advance_s = ((state_r == ST_WAIT_COUNT) && (count_in_s == {ADDR_WIDTH{1'b0}})) ||
                ((state_r == ST_RD_PART) && (out_rd_address == count_r));
  end

  // Pass sequencer with registered read-port and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r                  <= ST_IDLE;
      cell_x_r                 <= CELL_ONE;
      cell_y_r                 <= CELL_ONE;
      cell_z_r                 <= CELL_ONE;
      count_r                  <= {ADDR_WIDTH{1'b0}};
      wait_r                   <= 2'd0;
      out_rd_cell              <= {(3*CELL_ID_WIDTH){1'b0}};
      out_rd_address           <= {ADDR_WIDTH{1'b0}};
      out_rd_en                <= 1'b0;
      out_motion_update_enable <= 1'b0;
      out_busy                 <= 1'b0;
      out_done                 <= 1'b0;
    end else if (advance_s) begin
      cell_x_r       <= nxt_x_s;
      cell_y_r       <= nxt_y_s;
      cell_z_r       <= nxt_z_s;
      out_rd_address <= {ADDR_WIDTH{1'b0}};
      if (last_cell_s) begin
        state_r   <= ST_DRAIN;
        out_rd_en <= 1'b0;
        wait_r    <= 2'd0;
      end else begin
        state_r     <= ST_RD_COUNT;
        out_rd_en   <= 1'b1;
        out_rd_cell <= pack_cell(nxt_x_s, nxt_y_s, nxt_z_s);
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r                  <= ST_RD_COUNT;
            out_rd_en                <= 1'b1;
            out_rd_address           <= {ADDR_WIDTH{1'b0}};
            out_rd_cell              <= pack_cell(cell_x_r, cell_y_r, cell_z_r);
            out_motion_update_enable <= 1'b1;
            out_busy                 <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RD_COUNT: begin
          state_r   <= ST_WAIT_COUNT;
          out_rd_en <= 1'b0;
        end
        ST_WAIT_COUNT: begin
          state_r        <= ST_RD_PART;
          count_r        <= count_in_s;
          out_rd_en      <= 1'b1;
          out_rd_address <= ADDR_ONE;
        end
        ST_RD_PART: begin
          out_rd_en      <= 1'b1;
          out_rd_address <= out_rd_address + ADDR_ONE;
        end
        ST_DRAIN: begin
          if (wait_r == 2'd1) begin
            state_r                  <= ST_SETTLE;
            wait_r                   <= 2'd0;
            out_motion_update_enable <= 1'b0;
            out_rd_cell              <= {(3*CELL_ID_WIDTH){1'b0}};
          end else begin
            wait_r <= wait_r + 2'd1;
          end
        end
        ST_SETTLE: begin
          if (wait_r == 2'd2) begin
            state_r  <= ST_DONE;
            wait_r   <= 2'd0;
            out_done <= 1'b1;
          end else begin
            wait_r <= wait_r + 2'd1;
          end
        end
        ST_DONE: begin
          state_r  <= ST_IDLE;
          out_done <= 1'b0;
          out_busy <= 1'b0;
        end
        default: begin
          state_r                  <= ST_IDLE;
          out_rd_en                <= 1'b0;
          out_motion_update_enable <= 1'b0;
          out_busy                 <= 1'b0;
          out_done                 <= 1'b0;
        end
      endcase
    end
  end

  pos_wrap #(.DATA_WIDTH(DATA_WIDTH), .CELL_ID_WIDTH(CELL_ID_WIDTH),
             .OFFSET_WIDTH(OFFSET_WIDTH), .CELL_NUM(CELL_NUM_X)) u_wrap_x (
    .pos(in_pos[DATA_WIDTH-1:0]), .vel(in_vel[DATA_WIDTH-1:0]),
    .new_pos(new_x_s), .new_cell(dst_x_s));

  pos_wrap #(.DATA_WIDTH(DATA_WIDTH), .CELL_ID_WIDTH(CELL_ID_WIDTH),
             .OFFSET_WIDTH(OFFSET_WIDTH), .CELL_NUM(CELL_NUM_Y)) u_wrap_y (
    .pos(in_pos[2*DATA_WIDTH-1:DATA_WIDTH]), .vel(in_vel[2*DATA_WIDTH-1:DATA_WIDTH]),
    .new_pos(new_y_s), .new_cell(dst_y_s));

  pos_wrap #(.DATA_WIDTH(DATA_WIDTH), .CELL_ID_WIDTH(CELL_ID_WIDTH),
             .OFFSET_WIDTH(OFFSET_WIDTH), .CELL_NUM(CELL_NUM_Z)) u_wrap_z (
    .pos(in_pos[3*DATA_WIDTH-1:2*DATA_WIDTH]), .vel(in_vel[3*DATA_WIDTH-1:2*DATA_WIDTH]),
    .new_pos(new_z_s), .new_cell(dst_z_s));

  // Particle reads return one cycle later; register the integrated result, zero when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r            <= 1'b0;
      out_data_valid    <= 1'b0;
      out_data          <= {(3*DATA_WIDTH){1'b0}};
      out_data_dst_cell <= {(3*CELL_ID_WIDTH){1'b0}};
    end else begin
      pend_r         <= out_rd_en && (out_rd_address != {ADDR_WIDTH{1'b0}});
      out_data_valid <= pend_r;
      if (pend_r) begin
        out_data          <= pack_data(new_x_s, new_y_s, new_z_s);
        out_data_dst_cell <= pack_cell(dst_x_s, dst_y_s, dst_z_s);
      end else begin
        out_data          <= {(3*DATA_WIDTH){1'b0}};
        out_data_dst_cell <= {(3*CELL_ID_WIDTH){1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_motion_update_dispatch.sv
// Scoreboard bench: cache model answers reads, a reference model predicts every broadcast.
module tb_motion_update_dispatch;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int AW = 8;
  localparam int PN = 220;
  localparam int NX = 3;
  localparam int NY = 3;
  localparam int NZ = 3;
  localparam int NCELLS = NX * NY * NZ;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [3*CW-1:0] out_rd_cell;
  logic [AW-1:0]   out_rd_address;
  logic            out_rd_en;
  logic [3*DW-1:0] in_pos = '0;
  logic [3*DW-1:0] in_vel = '0;
  logic            out_motion_update_enable;
  logic [3*DW-1:0] out_data;
  logic [3*CW-1:0] out_data_dst_cell;
  logic            out_data_valid;
  logic            out_busy;
  logic            out_done;

  always #5 clk = ~clk;

  motion_update_dispatch dut (
    .clk(clk), .rst(rst), .start(start),
    .out_rd_cell(out_rd_cell), .out_rd_address(out_rd_address), .out_rd_en(out_rd_en),
    .in_pos(in_pos), .in_vel(in_vel),
    .out_motion_update_enable(out_motion_update_enable),
    .out_data(out_data), .out_data_dst_cell(out_data_dst_cell),
    .out_data_valid(out_data_valid), .out_busy(out_busy), .out_done(out_done));

  logic [3*DW-1:0]      pos_mem [1:NX][1:NY][1:NZ][0:255];
  logic [3*DW-1:0]      vel_mem [1:NX][1:NY][1:NZ][0:255];
  int                   cnt_raw [1:NX][1:NY][1:NZ];
  logic [3*DW+3*CW-1:0] exp_q[$];
  logic [3*DW+3*CW-1:0] got_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int rd_total = 0;
  int rd_sat   = 0;
  int rd_max   = 0;
  int settle_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: integer add, then cell index taken modulo N in 1..N.
  function automatic logic [DW-1:0] model_axis(input logic [DW-1:0] p, input logic [DW-1:0] v,
                                               input int n);
    longint s, c, off;
    logic [63:0] cv, ov;
    s   = longint'(p) + longint'($signed(v));
    c   = s / (longint'(1) << 28);
    off = s % (longint'(1) << 28);
    c   = ((c - 1 + n) % n) + 1;
    cv  = 64'(c);
    ov  = 64'(off);
    return {cv[3:0], ov[27:0]};
  endfunction

  function automatic logic [DW-1:0] rand_coord(input int n);
    logic [3:0]  c;
    logic [27:0] o;
    c = 4'($urandom_range(1, n));
    o = 28'($urandom);
    return {c, o};
  endfunction

  function automatic logic [DW-1:0] rand_vel();
    logic [DW-1:0] v;
    v = {4'b0, 28'($urandom)};
    if ($urandom_range(0, 1) == 1) v = -v;
    return v;
  endfunction

  task automatic set_count(input int x, input int y, input int z, input int n);
    cnt_raw[x][y][z] = n;
    pos_mem[x][y][z][0][AW-1:0] = 8'(n);
  endtask

  task automatic fill_cells(input int maxcnt);
    for (int x = 1; x <= NX; x++)
      for (int y = 1; y <= NY; y++)
        for (int z = 1; z <= NZ; z++) begin
          pos_mem[x][y][z][0] = {$urandom, $urandom, $urandom};
          vel_mem[x][y][z][0] = {$urandom, $urandom, $urandom};
          set_count(x, y, z, $urandom_range(0, maxcnt));
          for (int i = 1; i < 256; i++) begin
            pos_mem[x][y][z][i] = {rand_coord(NZ), rand_coord(NY), rand_coord(NX)};
            vel_mem[x][y][z][i] = {rand_vel(), rand_vel(), rand_vel()};
          end
        end
  endtask

  task automatic build_expected(output int total);
    int n;
    logic [3*DW-1:0] p, v;
    logic [DW-1:0] ax, ay, az;
    total = 0;
    exp_q.delete();
    for (int x = 1; x <= NX; x++)
      for (int y = 1; y <= NY; y++)
        for (int z = 1; z <= NZ; z++) begin
          n = (cnt_raw[x][y][z] > PN) ? PN : cnt_raw[x][y][z];
          for (int i = 1; i <= n; i++) begin
            p  = pos_mem[x][y][z][i];
            v  = vel_mem[x][y][z][i];
            ax = model_axis(p[DW-1:0], v[DW-1:0], NX);
            ay = model_axis(p[2*DW-1:DW], v[2*DW-1:DW], NY);
            az = model_axis(p[3*DW-1:2*DW], v[3*DW-1:2*DW], NZ);
            exp_q.push_back({az, ay, ax, ax[31:28], ay[31:28], az[31:28]});
            total++;
          end
        end
  endtask

  // Cache model: request seen during cycle t is answered from mid-cycle t+1.
  initial begin
    logic          req_en;
    logic [3*CW-1:0] req_cell;
    logic [AW-1:0] req_addr;
    int cx, cy, cz;
    req_en = 1'b0;
    req_cell = '0;
    req_addr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        req_en = 1'b0;
        in_pos = '0;
        in_vel = '0;
      end else begin
        cx = int'(req_cell[11:8]);
        cy = int'(req_cell[7:4]);
        cz = int'(req_cell[3:0]);
        if (req_en && cx >= 1 && cx <= NX && cy >= 1 && cy <= NY && cz >= 1 && cz <= NZ) begin
          in_pos = pos_mem[cx][cy][cz][req_addr];
          in_vel = vel_mem[cx][cy][cz][req_addr];
        end else begin
          in_pos = '0;
          in_vel = '0;
        end
        req_en   = out_rd_en;
        req_cell = out_rd_cell;
        req_addr = out_rd_address;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a valid broadcast.
  initial begin
    logic [3*DW+3*CW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_rd_en && out_rd_address != 8'd0) begin
          rd_total++;
          if (out_rd_cell == 12'h222) begin
            rd_sat++;
            if (int'(out_rd_address) > rd_max) rd_max = int'(out_rd_address);
          end
        end
        if (out_busy && !out_motion_update_enable && !out_done) settle_cnt++;
        if (out_data_valid) begin
          got_q.push_back({out_data, out_data_dst_cell});
          if (exp_q.size() == 0) begin
            check("valid_without_expectation", 128'(out_data_valid), 128'd0);
          end else begin
            e = exp_q.pop_front();
            check("data", 128'(out_data), 128'(e[3*DW+3*CW-1:3*CW]));
            check("dst_cell", 128'(out_data_dst_cell), 128'(e[3*CW-1:0]));
            check("enable_with_valid", 128'(out_motion_update_enable), 128'd1);
          end
        end else begin
          check("idle_bus_zero", 128'({out_data, out_data_dst_cell}), 128'd0);
        end
      end
    end
  end

  task automatic run_pass(input string tag, input bit mid_start);
    int total, k;
    build_expected(total);
    got_q.delete();
    rd_total = 0;
    rd_sat = 0;
    rd_max = 0;
    settle_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    check({tag, "_busy_after_start"}, 128'(out_busy), 128'd1);
    check({tag, "_enable_after_start"}, 128'(out_motion_update_enable), 128'd1);
    while (!out_done && k < 5000) begin
      @(negedge clk);
      k++;
      start = (mid_start && k == 40) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    check({tag, "_pass_length"}, 128'(k), 128'(2 * NCELLS + total + 6));
    check({tag, "_settle_cycles"}, 128'(settle_cnt), 128'd3);
    check({tag, "_read_count"}, 128'(rd_total), 128'(total));
    check({tag, "_valid_count"}, 128'(got_q.size()), 128'(total));
    check({tag, "_scoreboard_empty"}, 128'(exp_q.size()), 128'd0);
    @(negedge clk);
    check({tag, "_idle_after_done"}, 128'({out_busy, out_done, out_motion_update_enable}), 128'd0);
  endtask

  task automatic check_directed();
    logic [3*DW+3*CW-1:0] g;
    if (got_q.size() < 5) begin
      check("directed_valid_count", 128'(got_q.size()), 128'd5);
    end else begin
      g = got_q[0];
      check("inc_x", 128'(g[3*CW+DW-1:3*CW]), 128'h1000_0010);
      check("inc_dst", 128'(g[3*CW-1:0]), 128'h111);
      g = got_q[2];
      check("carry_x", 128'(g[3*CW+DW-1:3*CW]), 128'h2000_0010);
      check("carry_dst", 128'(g[3*CW-1:0]), 128'h211);
      g = got_q[3];
      check("wrap_down_x", 128'(g[3*CW+DW-1:3*CW]), 128'h3FFF_FFFC);
      check("wrap_down_dst", 128'(g[3*CW-1:0]), 128'h311);
      g = got_q[4];
      check("wrap_up_x", 128'(g[3*CW+DW-1:3*CW]), 128'h1000_0004);
      check("wrap_up_dst", 128'(g[3*CW-1:0]), 128'h111);
    end
  endtask

  task automatic put_particle(input int z, input int i, input logic [DW-1:0] px,
                              input logic [DW-1:0] vx);
    pos_mem[1][1][z][i] = {32'h1000_0000, 32'h1000_0000, px};
    vel_mem[1][1][z][i] = {32'h0, 32'h0, vx};
  endtask

  initial begin
    int total, k;
    fill_cells(5);
    repeat (3) @(negedge clk);
    check("reset_outputs", 128'({out_rd_cell, out_rd_address, out_rd_en, out_motion_update_enable,
          out_data, out_data_dst_cell, out_data_valid, out_busy, out_done}), 128'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Pass 1: hand-placed increment, carry and both wrap directions around an empty cell.
    set_count(1, 1, 1, 2);
    put_particle(1, 1, 32'h1000_0000, 32'h0000_0010);
    put_particle(1, 2, 32'h1000_0000, 32'h0000_0010);
    set_count(1, 1, 2, 0);
    set_count(1, 1, 3, 3);
    put_particle(3, 1, 32'h1FFF_FFF0, 32'h0000_0020);
    put_particle(3, 2, 32'h1000_0004, 32'hFFFF_FFF8);
    put_particle(3, 3, 32'h3FFF_FFFC, 32'h0000_0008);
    run_pass("p1", 1'b0);
    check_directed();

    // Pass 2: saturated count field and a stray start mid-pass.
    fill_cells(4);
    set_count(2, 2, 2, 250);
    run_pass("p2", 1'b1);
    check("sat_reads", 128'(rd_sat), 128'd220);
    check("sat_last_addr", 128'(rd_max), 128'd220);

    // Pass 3: reset while particle reads are in flight, then a clean pass.
    fill_cells(6);
    set_count(1, 1, 1, 6);
    build_expected(total);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(out_rd_en && out_rd_address == 8'd3) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("reach_rd_part", 128'(k < 200), 128'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midpass_reset_outputs", 128'({out_rd_cell, out_rd_address, out_rd_en,
          out_motion_update_enable, out_data, out_data_dst_cell, out_data_valid, out_busy,
          out_done}), 128'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 128'({out_busy, out_rd_en, out_motion_update_enable}), 128'd0);
    run_pass("p4", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
